// File: rtl/parking_pkg.sv
// Shared encodings and default thresholds for the tyre pulse classifier.
package parking_pkg;

  // Classification reported with each event.
  typedef enum logic [1:0] {
    CLS_NONE  = 2'b00,
    CLS_CYCLE = 2'b01,
    CLS_CAR   = 2'b10,
    CLS_FAULT = 2'b11
  } cls_t;

  // Classifier FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MEASURE  = 2'b01,
    ST_PRESENT  = 2'b10,
    ST_WAIT_LOW = 2'b11
  } state_t;

  // Default pulse-width thresholds in clock cycles.
  localparam int DEF_MIN_W     = 2;
  localparam int DEF_CYCLE_MAX = 5;
  localparam int DEF_CAR_MAX   = 10;

endpackage

// File: rtl/tyre_pulse_classifier_if.sv
// Classification event channel (valid/ready) towards the parking controller.
interface tyre_pulse_classifier_if
  import parking_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  logic             evt_valid;
  logic             evt_ready;
  cls_t             evt_class;
  logic [CNT_W-1:0] evt_width;

  modport master (output evt_valid, output evt_class, output evt_width, input evt_ready);
  modport slave  (input evt_valid, input evt_class, input evt_width, output evt_ready);

endinterface

// File: rtl/parking_occupancy_ctr.sv
// Car-bay occupancy counter: saturates at SLOTS, never underflows.
module parking_occupancy_ctr #(
  parameter int SLOTS = 8,
  parameter int OCC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [OCC_W-1:0] o_occupancy,
  output logic             o_full,
  output logic             o_full_reject
);

  localparam logic [OCC_W-1:0] L_SLOTS = OCC_W'(SLOTS);

  generate
    if ((2 ** OCC_W) <= SLOTS) begin : g_bad_occ_w
      $error("parking_occupancy_ctr: OCC_W too narrow for SLOTS");
    end
  endgenerate

  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_nxt;
  logic             r_full;
  logic             r_reject;
  logic             w_reject_nxt;

  // Next occupancy: simultaneous arrive and leave cancel out.
  always_comb begin
    w_occ_nxt    = r_occ;
    w_reject_nxt = 1'b0;
    if (i_inc && !i_dec) begin
      if (r_full) w_reject_nxt = 1'b1;
      else        w_occ_nxt    = r_occ + 1'b1;
    end else if (i_dec && !i_inc && (r_occ != '0)) begin
      w_occ_nxt = r_occ - 1'b1;
    end
  end

  // Register count, full flag (tracks the new count) and reject pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ    <= '0;
      r_full   <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_occ    <= w_occ_nxt;
      r_full   <= (w_occ_nxt == L_SLOTS);
      r_reject <= w_reject_nxt;
    end
  end

  assign o_occupancy   = r_occ;
  assign o_full        = r_full;
  assign o_full_reject = r_reject;

endmodule

// File: rtl/tyre_pulse_classifier.sv
// Measures debounced tyre pulses, classifies them and reports one event per pulse.
module tyre_pulse_classifier
  import parking_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MIN_W     = DEF_MIN_W,
  parameter int CYCLE_MAX = DEF_CYCLE_MAX,
  parameter int CAR_MAX   = DEF_CAR_MAX,
  parameter int SLOTS     = 8,
  parameter int OCC_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_db_in,
  input  logic                    i_car_exit,
  tyre_pulse_classifier_if.master evt,
  output logic [OCC_W-1:0]        o_occupancy,
  output logic                    o_full,
  output logic                    o_full_reject,
  output logic                    o_overrun
);

  generate
    if (MIN_W > CYCLE_MAX || CYCLE_MAX >= CAR_MAX || CAR_MAX >= (2 ** CNT_W) - 1) begin : g_bad_thr
      $error("tyre_pulse_classifier: inconsistent width thresholds");
    end
  endgenerate

  localparam logic [CNT_W-1:0] L_MIN_W     = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] L_CYCLE_MAX = CNT_W'(CYCLE_MAX);
  localparam logic [CNT_W-1:0] L_CAR_MAX   = CNT_W'(CAR_MAX);
  localparam logic [CNT_W-1:0] L_W_MAX     = '1;

  state_t           r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_width,     w_width_nxt;
  logic [CNT_W-1:0] r_evt_width, w_evt_width_nxt;
  cls_t             r_class,     w_class_nxt;
  logic             r_valid,     w_valid_nxt;
  logic             r_stuck,     w_stuck_nxt;
  logic             r_overrun,   w_overrun_nxt;
  logic             r_db_q;
  logic             w_handshake;

  assign w_handshake = r_valid & evt.evt_ready;

  // Next-state and event-register logic for the classifier FSM.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_nxt     = r_state;
    w_width_nxt     = r_width;
    w_evt_width_nxt = r_evt_width;
    w_class_nxt     = r_class;
    w_valid_nxt     = r_valid;
    w_stuck_nxt     = r_stuck;
    w_overrun_nxt   = (r_state == ST_PRESENT) && i_db_in && !r_db_q;
    case (r_state)
      ST_IDLE: begin
        if (i_db_in) begin
          w_state_nxt = ST_MEASURE;
          w_width_nxt = CNT_W'(1);
        end
      end
      ST_MEASURE: begin
        if (i_db_in) begin
          if (r_width == L_W_MAX) begin
            // Sensor held high past the counter range: report a fault and
            // insist on a low level before measuring again.
            w_state_nxt     = ST_PRESENT;
            w_valid_nxt     = 1'b1;
            w_class_nxt     = CLS_FAULT;
            w_evt_width_nxt = L_W_MAX;
            w_stuck_nxt     = 1'b1;
          end else begin
            w_width_nxt = r_width + 1'b1;
          end
        end else if (r_width < L_MIN_W) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt     = ST_PRESENT;
          w_valid_nxt     = 1'b1;
          w_evt_width_nxt = r_width;
          if (r_width <= L_CYCLE_MAX)    w_class_nxt = CLS_CYCLE;
          else if (r_width <= L_CAR_MAX) w_class_nxt = CLS_CAR;
          else                           w_class_nxt = CLS_FAULT;
        end
      end
      ST_PRESENT: begin
        if (w_handshake) begin
          w_valid_nxt = 1'b0;
          w_class_nxt = CLS_NONE;
          w_stuck_nxt = 1'b0;
          // A pulse that began while the event was pending is never measured.
          w_state_nxt = (r_stuck || i_db_in) ? ST_WAIT_LOW : ST_IDLE;
        end
      end
      ST_WAIT_LOW: begin
        if (!i_db_in) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_WAIT_LOW;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state     <= ST_WAIT_LOW;
      r_width     <= '0;
      r_evt_width <= '0;
      r_class     <= CLS_NONE;
      r_valid     <= 1'b0;
      r_stuck     <= 1'b0;
      r_overrun   <= 1'b0;
      r_db_q      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_width     <= w_width_nxt;
      r_evt_width <= w_evt_width_nxt;
      r_class     <= w_class_nxt;
      r_valid     <= w_valid_nxt;
      r_stuck     <= w_stuck_nxt;
      r_overrun   <= w_overrun_nxt;
      r_db_q      <= i_db_in;
    end
  end

  assign evt.evt_valid = r_valid;
  assign evt.evt_class = r_class;
  assign evt.evt_width = r_evt_width;
  assign o_overrun     = r_overrun;

  parking_occupancy_ctr #(
    .SLOTS (SLOTS),
    .OCC_W (OCC_W)
  ) u_occupancy (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_inc         (w_handshake && (r_class == CLS_CAR)),
    .i_dec         (i_car_exit),
    .o_occupancy   (o_occupancy),
    .o_full        (o_full),
    .o_full_reject (o_full_reject)
  );

endmodule

// File: tb/tb_tyre_pulse_classifier.sv
// Self-checking bench for tyre_pulse_classifier with a pulse-level reference model.
module tb_tyre_pulse_classifier;
  import parking_pkg::*;

  localparam int CNT_W = 8;
  localparam int SLOTS = 8;
  localparam int OCC_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             db_in;
  logic             car_exit;
  logic [OCC_W-1:0] occupancy;
  logic             full;
  logic             full_reject;
  logic             overrun;

  tyre_pulse_classifier_if #(.CNT_W(CNT_W)) ifc ();

  tyre_pulse_classifier #(
    .CNT_W (CNT_W),
    .SLOTS (SLOTS),
    .OCC_W (OCC_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_db_in       (db_in),
    .i_car_exit    (car_exit),
    .evt           (ifc.master),
    .o_occupancy   (occupancy),
    .o_full        (full),
    .o_full_reject (full_reject),
    .o_overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    cls_t             c;
    logic [CNT_W-1:0] w;
  } evt_t;

  evt_t got_q[$];
  evt_t exp_q[$];
  int   n_vec, n_err;
  int   n_valid_cycles, n_overrun, n_rej;
  int   exp_rej, exp_occ;
  logic lat;

  // Reference classification of a pulse that was high for h samples.
  function automatic cls_t model_class(input int h);
    if (h < DEF_MIN_W)               return CLS_NONE;
    else if (h > 255)                return CLS_FAULT;
    else if (h <= DEF_CYCLE_MAX)     return CLS_CYCLE;
    else if (h <= DEF_CAR_MAX)       return CLS_CAR;
    else                             return CLS_FAULT;
  endfunction

  function automatic logic [CNT_W-1:0] model_width(input int h);
    int v;
    v = (h > 255) ? 255 : h;
    return v[CNT_W-1:0];
  endfunction

  // One clock: apply inputs, advance past the edge, log handshakes and update the occupancy model.
  task automatic step(input logic db, input logic rdy, input logic ex, input logic inc);
    logic pv, rs;
    evt_t pe;
    db_in         = db;
    ifc.evt_ready = rdy;
    car_exit      = ex;
    pv            = ifc.evt_valid;
    pe.c          = ifc.evt_class;
    pe.w          = ifc.evt_width;
    rs            = rst_n;
    @(posedge clk);
    #1;
    if (rs && pv && rdy) got_q.push_back(pe);
    if (ifc.evt_valid === 1'b1) n_valid_cycles++;
    if (overrun === 1'b1)       n_overrun++;
    if (full_reject === 1'b1)   n_rej++;
    if (!rs) exp_occ = 0;
    else if (inc && !ex) begin
      if (exp_occ == SLOTS) exp_rej++;
      else                  exp_occ++;
    end else if (ex && !inc && exp_occ > 0) begin
      exp_occ--;
    end
  endtask

  // Drive a pulse of h highs and gap (>=2) lows. With rdy=1 the handshake lands on the second low.
  // ex_mode: 0 no car_exit, 1 car_exit on the handshake cycle, 2 random car_exit.
  task automatic pulse(input int h, input int gap, input logic rdy, input int ex_mode,
                       output logic lat_valid);
    cls_t c;
    logic ex;
    evt_t e;
    c = model_class(h);
    lat_valid = 1'b0;
    for (int i = 0; i < h; i++) begin
      ex = (ex_mode == 2) && ($urandom_range(0, 11) == 0);
      step(1'b1, rdy, ex, 1'b0);
    end
    for (int i = 0; i < gap; i++) begin
      ex = ((ex_mode == 1) && (i == 1)) || ((ex_mode == 2) && ($urandom_range(0, 11) == 0));
      step(1'b0, rdy, ex, (i == 1) && rdy && (c == CLS_CAR));
      if (i == 0) lat_valid = ifc.evt_valid;
    end
    if (c != CLS_NONE && rdy) begin
      e.c = c;
      e.w = model_width(h);
      exp_q.push_back(e);
    end
  endtask

  task automatic clr();
    got_q.delete();
    exp_q.delete();
    n_valid_cycles = 0;
    n_overrun      = 0;
    n_rej          = 0;
    exp_rej        = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    clr();
  endtask

  // Compare logged events with the model queue, then empty both.
  task automatic score(input string tag);
    int n;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL %s_count: got %0d events want %0d", tag, got_q.size(), exp_q.size());
    end
    n_vec++;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s_evt%0d: got class %b width %0d want class %b width %0d",
                 tag, i, got_q[i].c, got_q[i].w, exp_q[i].c, exp_q[i].w);
      end
      n_vec++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_occ(input string tag, input int want_occ, input logic want_full);
    if (occupancy !== OCC_W'(want_occ)) begin
      n_err++;
      $display("FAIL %s_occ: got %0d want %0d", tag, occupancy, want_occ);
    end
    n_vec++;
    if (full !== want_full) begin
      n_err++;
      $display("FAIL %s_full: got %b want %b", tag, full, want_full);
    end
    n_vec++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    if (ifc.evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ifc.evt_valid); end
    n_vec++;
    if (ifc.evt_class !== CLS_NONE) begin n_err++; $display("FAIL reset_class: got %b want 00", ifc.evt_class); end
    n_vec++;
    if (ifc.evt_width !== '0) begin n_err++; $display("FAIL reset_width: got %0d want 0", ifc.evt_width); end
    n_vec++;
    if (full_reject !== 1'b0) begin n_err++; $display("FAIL reset_reject: got %b want 0", full_reject); end
    n_vec++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_vec++;
    check_occ("reset", 0, 1'b0);
    rst_n = 1'b1;
    clr();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    if (n_valid_cycles !== 0) begin n_err++; $display("FAIL reset_held_tyre_valid: got %0d cycles want 0", n_valid_cycles); end
    n_vec++;
    score("reset_held_tyre");
  endtask

  task automatic test_classes();
    int hs[4];
    hs = '{1, 3, 8, 12};
    apply_reset();
    exp_occ = 0;
    foreach (hs[k]) begin
      n_valid_cycles = 0;
      pulse(hs[k], 3, 1'b1, 0, lat);
      if (lat !== (hs[k] >= DEF_MIN_W)) begin
        n_err++; $display("FAIL classes_latency_h%0d: got valid %b want %b", hs[k], lat, hs[k] >= DEF_MIN_W);
      end
      n_vec++;
      if (n_valid_cycles !== ((hs[k] >= DEF_MIN_W) ? 1 : 0)) begin
        n_err++; $display("FAIL classes_valid_len_h%0d: got %0d cycles", hs[k], n_valid_cycles);
      end
      n_vec++;
      score($sformatf("classes_h%0d", hs[k]));
    end
    check_occ("classes", exp_occ, 1'b0);
  endtask

  task automatic test_backpressure();
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step((i >= 3 && i < 7), 1'b0, 1'b0, 1'b0);
      if (ifc.evt_valid !== 1'b1 || ifc.evt_class !== CLS_CAR || ifc.evt_width !== 8'd8) bad++;
    end
    if (bad !== 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    n_vec++;
    if (n_overrun !== 1) begin n_err++; $display("FAIL bp_overrun: got %0d pulses want 1", n_overrun); end
    n_vec++;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    if (ifc.evt_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_drop: got %b want 0", ifc.evt_valid); end
    n_vec++;
    if (ifc.evt_class !== CLS_NONE) begin n_err++; $display("FAIL bp_class_clear: got %b want 00", ifc.evt_class); end
    n_vec++;
    if (ifc.evt_width !== 8'd8) begin n_err++; $display("FAIL bp_width_hold: got %0d want 8", ifc.evt_width); end
    n_vec++;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back('{c: CLS_CAR, w: 8'd8});
    score("bp");
    check_occ("bp", 1, 1'b0);
  endtask

  task automatic test_saturation();
    int rise;
    apply_reset();
    rise = -1;
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (ifc.evt_valid === 1'b1 && rise < 0) rise = i;
    end
    if (rise !== 256) begin n_err++; $display("FAIL sat_rise: got sample %0d want 256", rise); end
    n_vec++;
    exp_q.push_back('{c: CLS_FAULT, w: 8'd255});
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    score("sat");
    if (n_overrun !== 0) begin n_err++; $display("FAIL sat_overrun: got %0d want 0", n_overrun); end
    n_vec++;
    pulse(3, 3, 1'b1, 0, lat);
    score("sat_rearm");
  endtask

  task automatic test_occupancy();
    apply_reset();
    for (int k = 0; k < 8; k++) pulse($urandom_range(6, 10), 3, 1'b1, 0, lat);
    check_occ("occ_fill", 8, 1'b1);
    if (n_rej !== 0) begin n_err++; $display("FAIL occ_fill_reject: got %0d want 0", n_rej); end
    n_vec++;
    pulse(7, 3, 1'b1, 0, lat);
    check_occ("occ_ninth", 8, 1'b1);
    if (n_rej !== 1) begin n_err++; $display("FAIL occ_ninth_reject: got %0d want 1", n_rej); end
    n_vec++;
    pulse(9, 3, 1'b1, 1, lat);
    check_occ("occ_same_cycle", 8, 1'b1);
    if (n_rej !== 1) begin n_err++; $display("FAIL occ_same_cycle_reject: got %0d want 1", n_rej); end
    n_vec++;
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    check_occ("occ_drain", 0, 1'b0);
    pulse(6, 3, 1'b1, 1, lat);
    check_occ("occ_zero_same_cycle", 0, 1'b0);
    pulse(6, 3, 1'b1, 0, lat);
    check_occ("occ_after", exp_occ, 1'b0);
    if (exp_occ !== 1) begin n_err++; $display("FAIL occ_model: got %0d want 1", exp_occ); end
    n_vec++;
    score("occ");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    pulse(8, 3, 1'b1, 0, lat);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    if (ifc.evt_valid !== 1'b0) begin n_err++; $display("FAIL mid_meas_valid: got %b want 0", ifc.evt_valid); end
    n_vec++;
    check_occ("mid_meas", 0, 1'b0);
    rst_n = 1'b1;
    score("mid_before");
    n_valid_cycles = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    if (n_valid_cycles !== 0) begin n_err++; $display("FAIL mid_meas_spurious: got %0d cycles want 0", n_valid_cycles); end
    n_vec++;
    pulse(7, 3, 1'b1, 0, lat);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    if (ifc.evt_valid !== 1'b1) begin n_err++; $display("FAIL mid_present_enter: got %b want 1", ifc.evt_valid); end
    n_vec++;
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    if (ifc.evt_valid !== 1'b0) begin n_err++; $display("FAIL mid_present_valid: got %b want 0", ifc.evt_valid); end
    n_vec++;
    if (ifc.evt_class !== CLS_NONE) begin n_err++; $display("FAIL mid_present_class: got %b want 00", ifc.evt_class); end
    n_vec++;
    check_occ("mid_present", 0, 1'b0);
    rst_n = 1'b1;
    score("mid_car");
    n_valid_cycles = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    if (n_valid_cycles !== 0) begin n_err++; $display("FAIL mid_present_spurious: got %0d cycles want 0", n_valid_cycles); end
    n_vec++;
    score("mid_after");
    pulse(3, 3, 1'b1, 0, lat);
    score("mid_resume");
  endtask

  task automatic test_random();
    apply_reset();
    exp_occ = 0;
    for (int k = 0; k < 40; k++) begin
      pulse($urandom_range(1, 14), $urandom_range(2, 5), 1'b1, 2, lat);
    end
    score("rand");
    check_occ("rand", exp_occ, exp_occ == SLOTS);
    if (n_rej !== exp_rej) begin n_err++; $display("FAIL rand_reject: got %0d want %0d", n_rej, exp_rej); end
    n_vec++;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    exp_occ  = 0;
    rst_n    = 1'b0;
    db_in    = 1'b1;
    car_exit = 1'b0;
    ifc.evt_ready = 1'b1;
    clr();
    @(posedge clk);
    #1;
    test_reset();
    test_classes();
    test_backpressure();
    test_saturation();
    test_occupancy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tyre_pulse_classifier.md
Name: tyre_pulse_classifier

Overview:
- Sits directly downstream of the tyre debouncer and consumes its debounced tyre-contact output.
- Measures each high pulse in clock cycles and classifies it as noise, cycle tyre, car tyre or fault.
- Presents one classification event per pulse on a valid/ready interface to the parking controller.
- Maintains a car-bay occupancy count, with full and reject indications.

Parameters:
CNT_W, 8, width of pulse-width counter and evt_width
MIN_W, 2, shortest accepted pulse in cycles; shorter pulses are noise
CYCLE_MAX, 5, longest pulse classified as cycle tyre
CAR_MAX, 10, longest pulse classified as car tyre; longer is fault
SLOTS, 8, number of car bays (occupancy range 0..SLOTS)
OCC_W, 4, occupancy counter width; must satisfy 2^OCC_W > SLOTS

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous reset, active low
db_in  input  1  debounced tyre contact from debouncer, 1 = tyre present
evt_valid  output  1  classification event available
evt_ready  input  1  consumer accepts event
evt_class  output  2  00 none, 01 cycle, 10 car, 11 fault
evt_width  output  CNT_W  measured pulse width in cycles
car_exit  input  1  one-cycle pulse, a car left a bay
occupancy  output  OCC_W  occupied car bays
full  output  1  occupancy == SLOTS
full_reject  output  1  one-cycle pulse, car event accepted while full
overrun  output  1  one-cycle pulse, rising pulse lost while event pending

Behaviour:
- Reset: one clock, synchronous, active low (rst_n = 0 sampled at a clk edge). All outputs go to 0 and the state goes to WAIT_LOW. A tyre already on the sensor at reset release is therefore never measured.
- States: IDLE, MEASURE, PRESENT, WAIT_LOW.
- IDLE: db_in = 1 sampled -> MEASURE, width <= 1.
- MEASURE, db_in = 1, width < 2^CNT_W-1 -> width + 1.
- MEASURE, db_in = 1, width == 2^CNT_W-1 -> PRESENT with class 11 and evt_width all-ones. Set a stuck flag.
- MEASURE, db_in = 0 sampled, width < MIN_W -> IDLE. No event is produced.
- MEASURE, db_in = 0 sampled, otherwise -> PRESENT:
  - MIN_W..CYCLE_MAX -> class 01
  - CYCLE_MAX+1..CAR_MAX -> class 10
  - above CAR_MAX -> class 11
- Width semantics: a pulse sampled high on H consecutive edges reports evt_width = H.
- Latency: evt_valid rises on the same edge that samples db_in low.
- PRESENT: evt_valid = 1. evt_class and evt_width hold stable until evt_valid & evt_ready.
- On handshake: evt_valid <= 0 and evt_class <= 00. evt_width holds its last value. Next state is WAIT_LOW if the stuck flag is set (flag clears), else IDLE.
- PRESENT also covers a pulse that starts while an event is pending: it is not measured. overrun pulses for one cycle on every 0->1 transition of db_in seen in PRESENT, detected with a registered copy of db_in. The state still goes to WAIT_LOW after the handshake if db_in = 1 at that time.
- WAIT_LOW: db_in = 0 sampled -> IDLE.
- evt_ready while evt_valid = 0 is ignored.
- Occupancy update, let inc = handshake & class 10, dec = car_exit:
  - inc & !dec & !full -> +1
  - inc & !dec & full -> unchanged, full_reject pulses
  - dec & !inc & occupancy > 0 -> -1
  - dec & occupancy == 0 -> unchanged (no underflow)
  - inc & dec -> unchanged, no reject
- Occupancy arithmetic: unsigned OCC_W bits, never wraps.
- full: registered, equals (occupancy == SLOTS) in the same cycle occupancy updates.
- Classification compares: unsigned CNT_W. Elaboration error if MIN_W > CYCLE_MAX, CYCLE_MAX >= CAR_MAX, or CAR_MAX >= 2^CNT_W-1.

Decomposition:
- Shared package parking_pkg contains:
  - class encodings CLS_NONE/CLS_CYCLE/CLS_CAR/CLS_FAULT
  - state encoding constants
  - default thresholds MIN_W/CYCLE_MAX/CAR_MAX
- One sub-module, parking_occupancy_ctr:
  - inputs: inc, dec
  - outputs: occupancy, full, full_reject
  - parameters: SLOTS, OCC_W
- Classifier FSM stays in the top module.

Test Plan:
1. Reset: hold rst_n = 0 with db_in = 1, release, keep db_in high 7 cycles then low -> no event (WAIT_LOW), all outputs 0.
2. Classes, evt_ready tied 1: pulses of 1, 3, 8, 12 cycles ->
   - 1 cycle: no event
   - 3 cycles: class 01, width 3
   - 8 cycles: class 10, width 8
   - 12 cycles: class 11, width 12
   - each evt_valid is high for exactly one cycle, starting at the edge sampling low.
3. Backpressure and overrun:
   - 8-cycle pulse with evt_ready = 0 for 20 cycles, plus a 4-cycle pulse during the wait -> class 10 width 8 held stable, overrun pulses once, second pulse produces no event.
   - Raise evt_ready -> single handshake.
4. Saturation: db_in high 300 cycles with CNT_W = 8 -> fault event with width 255 after 255 high samples. After the handshake no new event until db_in has gone low, then high again.
5. Occupancy:
   - 8 car events -> occupancy 8, full = 1.
   - 9th car event -> full_reject pulses, occupancy stays 8.
   - car_exit in the same cycle as a car handshake -> occupancy unchanged.
   - 9 car_exit pulses from 8 -> ends at 0, no underflow.
6. Reset mid-operation: assert rst_n = 0 while in MEASURE and again while in PRESENT -> evt_valid and occupancy cleared next edge, no spurious event after release.
